// File: rtl/pulse_gray_timer_pkg.sv
// Shared types and helpers for pulse_gray_timer: FSM state encoding and the
// binary-to-Gray conversion used by the interval counter.
package pulse_gray_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TIMING = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Works on a 32-bit container; callers cast to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/pulse_gray_timer_gray_interval_counter.sv
// Binary interval counter with a Gray-coded view and a saturation flag.
// The owner decides when to clear or increment; this block never wraps on its own.
module gray_interval_counter
    import pulse_gray_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] bin_count,
    output logic [CNT_W-1:0] gray_count,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_bin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin <= '0;
        end else if (clr) begin
            r_bin <= '0;
        end else if (inc) begin
            r_bin <= r_bin + 1'b1;
        end
    end

    assign bin_count  = r_bin;
    assign gray_count = CNT_W'(bin2gray(32'(r_bin)));
    assign at_max     = (r_bin == CNT_MAX);

endmodule

// File: rtl/pulse_gray_timer.sv
// Weighted-pulse accumulator that times the interval between START_LVL and STOP_LVL
// and presents it Gray-coded with a valid/ack handshake. Define PULSE_GRAY_BIN_OUT_EN to add bin_count.
module pulse_gray_timer
    import pulse_gray_timer_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int ACC_W     = 10,
    parameter int CNT_W     = 8,
    parameter int START_LVL = 2,
    parameter int STOP_LVL  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [IN_W-1:0]  pulse,
    input  logic             result_ack,
    output logic [CNT_W-1:0] gray_count,
    output logic             result_valid,
    output logic             timeout,
    output logic             busy
`ifdef PULSE_GRAY_BIN_OUT_EN
    ,
    output logic [CNT_W-1:0] bin_count
`endif
);

    // Handshake: result_valid rises when an interval is latched and stays high,
    // with gray_count/timeout frozen, until result_ack is seen in DONE.
    localparam int               SUM_W   = ((ACC_W > IN_W) ? ACC_W : IN_W) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [ACC_W-1:0] START_V = ACC_W'(START_LVL);
    localparam logic [ACC_W-1:0] STOP_V  = ACC_W'(STOP_LVL);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_gray_count;
    logic [CNT_W-1:0] w_gray_nxt;
    logic             r_result_valid;
    logic             w_valid_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic             w_latch;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_bin;
    logic [CNT_W-1:0] w_cnt_gray;
    logic             w_cnt_at_max;
    logic [SUM_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_sat;

    gray_interval_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr        (w_cnt_clr),
        .inc        (w_cnt_inc),
        .bin_count  (w_cnt_bin),
        .gray_count (w_cnt_gray),
        .at_max     (w_cnt_at_max)
    );

    assign w_sum     = SUM_W'(r_acc) + SUM_W'(pulse);
    assign w_acc_sat = (w_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : w_sum[ACC_W-1:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_gray_nxt    = r_gray_count;
        w_valid_nxt   = r_result_valid;
        w_timeout_nxt = r_timeout;
        w_latch       = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;

        if (clear) begin
            w_state_nxt   = IDLE;
            w_acc_nxt     = '0;
            w_gray_nxt    = '0;
            w_valid_nxt   = 1'b0;
            w_timeout_nxt = 1'b0;
            w_cnt_clr     = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_clr = 1'b1;
                    if (enable) begin
                        w_acc_nxt = w_acc_sat;
                        if (r_acc >= START_V) begin
                            w_state_nxt = TIMING;
                        end
                    end
                end
                TIMING: begin
                    if (enable) begin
                        w_acc_nxt = w_acc_sat;
                        // Reaching STOP_LVL wins over saturation on the same edge.
                        if (r_acc >= STOP_V) begin
                            w_state_nxt   = DONE;
                            w_gray_nxt    = w_cnt_gray;
                            w_valid_nxt   = 1'b1;
                            w_timeout_nxt = 1'b0;
                            w_latch       = 1'b1;
                        end else if (w_cnt_at_max) begin
                            w_state_nxt   = DONE;
                            w_gray_nxt    = w_cnt_gray;
                            w_valid_nxt   = 1'b1;
                            w_timeout_nxt = 1'b1;
                            w_latch       = 1'b1;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        w_state_nxt = IDLE;
                        w_acc_nxt   = '0;
                        w_valid_nxt = 1'b0;
                        w_cnt_clr   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_cnt_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_gray_count   <= '0;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_acc          <= w_acc_nxt;
            r_gray_count   <= w_gray_nxt;
            r_result_valid <= w_valid_nxt;
            r_timeout      <= w_timeout_nxt;
        end
    end

`ifdef PULSE_GRAY_BIN_OUT_EN
    logic [CNT_W-1:0] r_bin_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin_count <= '0;
        end else if (clear) begin
            r_bin_count <= '0;
        end else if (w_latch) begin
            r_bin_count <= w_cnt_bin;
        end
    end

    assign bin_count = r_bin_count;
`else
    logic w_unused_bin;
    assign w_unused_bin = ^{w_cnt_bin, w_latch};
`endif

    assign gray_count   = r_gray_count;
    assign result_valid = r_result_valid;
    assign timeout      = r_timeout;
    assign busy         = (r_state == TIMING);

endmodule

// File: tb/tb_pulse_gray_timer.sv
// Directed bench for pulse_gray_timer: default build, a narrow saturating
// accumulator and a short counter that times out, each on its own instance.
module tb_pulse_gray_timer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       en0, clr0, ack0;
    logic [7:0] pulse0;
    logic [7:0] gray0;
    logic       valid0, to0, busy0;

    logic       en_s, clr_s, ack_s;
    logic [7:0] pulse_s;
    logic [7:0] gray_s;
    logic       valid_s, to_s, busy_s;

    logic       en_t, clr_t, ack_t;
    logic [7:0] pulse_t;
    logic [2:0] gray_t;
    logic       valid_t, to_t, busy_t;

`ifdef PULSE_GRAY_BIN_OUT_EN
    logic [7:0] bin0, bin_s;
    logic [2:0] bin_t;
`endif

    pulse_gray_timer dut0 (
        .clk(clk), .reset(reset), .enable(en0), .clear(clr0), .pulse(pulse0),
        .result_ack(ack0), .gray_count(gray0), .result_valid(valid0),
        .timeout(to0), .busy(busy0)
`ifdef PULSE_GRAY_BIN_OUT_EN
        , .bin_count(bin0)
`endif
    );

    pulse_gray_timer #(.ACC_W(4)) dut_s (
        .clk(clk), .reset(reset), .enable(en_s), .clear(clr_s), .pulse(pulse_s),
        .result_ack(ack_s), .gray_count(gray_s), .result_valid(valid_s),
        .timeout(to_s), .busy(busy_s)
`ifdef PULSE_GRAY_BIN_OUT_EN
        , .bin_count(bin_s)
`endif
    );

    pulse_gray_timer #(.CNT_W(3), .START_LVL(1), .STOP_LVL(1000), .ACC_W(10)) dut_t (
        .clk(clk), .reset(reset), .enable(en_t), .clear(clr_t), .pulse(pulse_t),
        .result_ack(ack_t), .gray_count(gray_t), .result_valid(valid_t),
        .timeout(to_t), .busy(busy_t)
`ifdef PULSE_GRAY_BIN_OUT_EN
        , .bin_count(bin_t)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check0(input string tag, input logic b, input logic v,
                          input logic t, input logic [7:0] g);
        check({tag, "_busy"},  32'(busy0),  32'(b));
        check({tag, "_valid"}, 32'(valid0), 32'(v));
        check({tag, "_tmo"},   32'(to0),    32'(t));
        check({tag, "_gray"},  32'(gray0),  32'(g));
    endtask

    task automatic take_result(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(1), 32'(0));
        end else begin
            check({tag, "_sb"}, 32'(gray0), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        reset = 1'b1;
        en0 = 0; clr0 = 0; ack0 = 0; pulse0 = 0;
        en_s = 0; clr_s = 0; ack_s = 0; pulse_s = 0;
        en_t = 0; clr_t = 0; ack_t = 0; pulse_t = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h02);

        tick();
        tick();
        check0("rst0", 0, 0, 0, 8'h00);
        check("rst_s_valid", 32'(valid_s), 32'(0));
        check("rst_t_busy", 32'(busy_t), 32'(0));
        reset = 1'b0;

        // Baseline interval: TIMING at edge 3, DONE at edge 7 with gray(3).
        en0 = 1; pulse0 = 8'd1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check0($sformatf("s1_e%0d", e), (e >= 3 && e <= 6), (e == 7), 0,
                   (e == 7) ? 8'h02 : 8'h00);
        end
        take_result("s1");
`ifdef PULSE_GRAY_BIN_OUT_EN
        check("s1_bin", 32'(bin0), 32'h03);
`endif

        for (int i = 1; i <= 5; i++) begin
            tick();
            check0($sformatf("hold%0d", i), 0, 1, 0, 8'h02);
        end

        ack0 = 1;
        tick();
        check0("ack", 0, 0, 0, 8'h02);

        // Ack held through the first two IDLE edges must not disturb the schedule.
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 2) ack0 = 0;
            check0($sformatf("s2_e%0d", e), (e >= 3 && e <= 6), (e == 7), 0, 8'h02);
        end
        take_result("s2");
        ack0 = 1;
        tick();
        ack0 = 0;

        // Stall inside TIMING after counter=1, acc=4.
        for (int e = 1; e <= 4; e++) tick();
        check("stall_pre_busy", 32'(busy0), 32'(1));
        en0 = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("stall%0d_busy", i), 32'(busy0), 32'(1));
            check($sformatf("stall%0d_acc", i), 32'(dut0.r_acc), 32'd4);
            check($sformatf("stall%0d_cnt", i), 32'(dut0.u_cnt.r_bin), 32'd1);
        end
        en0 = 1;
        tick();
        check0("stall_r1", 1, 0, 0, 8'h02);
        tick();
        check0("stall_r2", 1, 0, 0, 8'h02);
        tick();
        check0("stall_done", 0, 1, 0, 8'h02);
        take_result("stall");
        ack0 = 1;
        tick();
        ack0 = 0;

        // Asynchronous reset between edges while TIMING.
        for (int e = 1; e <= 4; e++) tick();
        check("ar_pre_busy", 32'(busy0), 32'(1));
        #3 reset = 1'b1;
        #1 check0("areset", 0, 0, 0, 8'h00);
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check0($sformatf("s3_e%0d", e), (e >= 3 && e <= 6), (e == 7), 0,
                   (e == 7) ? 8'h02 : 8'h00);
        end
        take_result("s3");

        clr0 = 1; ack0 = 1;
        tick();
        clr0 = 0; ack0 = 0; en0 = 0;
        check0("clr_ack", 0, 0, 0, 8'h00);
`ifdef PULSE_GRAY_BIN_OUT_EN
        check("clr_bin", 32'(bin0), 32'h00);
`endif

        // 4-bit accumulator fed 0xFF must pin at 15.
        en_s = 1; pulse_s = 8'hFF;
        tick();
        check("sat1_acc", 32'(dut_s.r_acc), 32'd15);
        check("sat1_busy", 32'(busy_s), 32'(0));
        tick();
        check("sat2_acc", 32'(dut_s.r_acc), 32'd15);
        check("sat2_busy", 32'(busy_s), 32'(1));
        tick();
        check("sat3_acc", 32'(dut_s.r_acc), 32'd15);
        check("sat3_valid", 32'(valid_s), 32'(1));
        check("sat3_busy", 32'(busy_s), 32'(0));
        check("sat3_gray", 32'(gray_s), 32'h00);
        check("sat3_tmo", 32'(to_s), 32'(0));
        en_s = 0; pulse_s = 0;

        // 3-bit counter runs out before the unreachable stop level.
        en_t = 1; pulse_t = 8'd1;
        tick();
        check("to_e1_busy", 32'(busy_t), 32'(0));
        pulse_t = 8'd0;
        tick();
        check("to_e2_busy", 32'(busy_t), 32'(1));
        for (int e = 3; e <= 10; e++) begin
            tick();
            check($sformatf("to_e%0d_busy", e), 32'(busy_t), 32'(e < 10));
            check($sformatf("to_e%0d_valid", e), 32'(valid_t), 32'(e == 10));
            check($sformatf("to_e%0d_tmo", e), 32'(to_t), 32'(e == 10));
            check($sformatf("to_e%0d_gray", e), 32'(gray_t), (e == 10) ? 32'h4 : 32'h0);
        end
        ack_t = 1;
        tick();
        ack_t = 0; en_t = 0;
        check("to_ack_valid", 32'(valid_t), 32'(0));
        check("to_ack_tmo", 32'(to_t), 32'(1));
        check("to_ack_gray", 32'(gray_t), 32'h4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_gray_timer.md
Name: pulse_gray_timer

Overview:
- Parametrised successor to the pulse-weighted Gray counter.
- Accumulates weighted pulses into a saturating accumulator. Starts an internal Gray-coded interval counter once the accumulator reaches START_LVL, and stops it at STOP_LVL.
- Presents the latched Gray interval with a valid/ack handshake plus a timeout flag.
- Sits between the pulse front-end and the readout/register logic of the tile.

Parameters:
- IN_W, 8, width of the pulse weight input
- ACC_W, 10, accumulator width (saturating)
- CNT_W, 8, interval counter / Gray output width
- START_LVL, 2, accumulator level that starts timing (must be < STOP_LVL)
- STOP_LVL, 6, accumulator level that stops timing (must be <= 2^ACC_W-1)

Ports:
- clk, input, 1, clock, rising edge
- reset, input, 1, asynchronous active-high reset
- enable, input, 1, advance enable; low freezes accumulator, counter and state
- clear, input, 1, synchronous clear of all state
- pulse, input, IN_W, weight added to the accumulator each enabled cycle
- result_ack, input, 1, consumer accepts the current result
- gray_count, output, CNT_W, latched Gray-coded interval
- result_valid, output, 1, gray_count/timeout hold a result
- timeout, output, 1, interval counter saturated before STOP_LVL
- busy, output, 1, state is TIMING

Behaviour:
- Reset (async) and clear (sync) take precedence in that order. Both force: state=IDLE, acc=0, counter=0, gray_count=0, result_valid=0, timeout=0, busy=0.
- Accumulator, each enabled cycle in IDLE/TIMING:
  - acc <= min(acc + pulse, 2^ACC_W-1), saturating with no wrap.
  - acc is held in DONE.
- All level comparisons use the registered acc, i.e. the value before this edge's add. A state transition therefore occurs one edge after the crossing add.
- States: IDLE, TIMING, DONE (2-bit encoding).
- IDLE:
  - counter held at 0.
  - If enable && acc >= START_LVL, go to TIMING at this edge; acc still adds.
- TIMING (busy=1), when enable:
  - If acc >= STOP_LVL: go to DONE, gray_count <= gray(counter), result_valid <= 1, timeout <= 0. The counter does not increment on this edge.
  - Else if counter == 2^CNT_W-1: go to DONE, gray_count <= gray(2^CNT_W-1), result_valid <= 1, timeout <= 1.
  - Else counter <= counter + 1.
- DONE:
  - Outputs are held stable until result_ack=1. result_ack is sampled regardless of enable.
  - On ack: state <= IDLE, acc <= 0, counter <= 0, result_valid <= 0 at that same edge. gray_count and timeout keep their last values until the next result.
- result_ack outside DONE is ignored.
- clear together with result_ack: clear wins.
- Reset or clear mid-TIMING aborts the interval; no result is produced.
- Gray encoding: g = b ^ (b >> 1), CNT_W bits.
- Every output is registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro PULSE_GRAY_BIN_OUT_EN.
- When defined: adds output port bin_count (CNT_W), the binary interval latched at the same edge as gray_count, with the same reset, clear and hold rules.
- When undefined: the port and its register do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state typedef (IDLE=2'd0, TIMING=2'd1, DONE=2'd2)
  - a bin-to-Gray conversion function
- One sub-module: gray_interval_counter (CNT_W). It provides:
  - inputs: clk, reset, clr, inc
  - outputs: binary count, Gray count, at_max flag
- The FSM and accumulator live in pulse_gray_timer.

Test Plan:
- Defaults, enable=1, pulse=1 from edge 1:
  - edge3 -> TIMING; edge7 -> DONE.
  - gray_count=8'h02, result_valid=1, timeout=0, busy=1 for edges 3..6.
- Saturation: ACC_W=4, pulse=8'hFF for 3 cycles -> acc stays 15, never wraps; DONE reached.
- Timeout: CNT_W=3, START_LVL=1, STOP_LVL=1000, ACC_W=10, pulse=1 then pulse=0 -> DONE with timeout=1, gray_count=3'b100.
- Handshake:
  - Hold result_ack=0 for 5 cycles in DONE -> outputs stable.
  - result_ack=1 -> result_valid=0 next edge, new interval can start.
  - ack while IDLE -> no effect.
- Mid-operation events:
  - enable=0 for 4 cycles inside TIMING -> counter and acc frozen, final gray_count unchanged vs. the no-stall run.
  - Async reset pulse between edges -> all outputs 0 immediately.
  - clear with result_ack in DONE -> IDLE, result_valid=0, gray_count=0.
- With PULSE_GRAY_BIN_OUT_EN: the first scenario gives bin_count=8'h03 alongside gray_count=8'h02.
